// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order retirement of out-of-order results.
// Optional `ROB_FWD_EN adds qj/qk operand lookup with same-cycle CDB bypass.
module rob_param #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             alloc_valid,
  input  logic [4:0]       alloc_dest,
  input  logic             alloc_writes,
  input  logic             alloc_is_store,
  input  logic             alloc_is_branch,
  input  logic             alloc_pred,
  input  logic [XLEN-1:0]  alloc_pc,
  input  logic [XLEN-1:0]  alloc_imm,
  output logic [TAG_W-1:0] alloc_tag,
  output logic             full,
  output logic             empty,
  output logic [TAG_W:0]   count,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_value,
  input  logic             cdb_taken,
  input  logic             store_done,
  output logic             head_ready,
  output logic [TAG_W-1:0] head_tag,
  output logic [4:0]       head_dest,
  output logic             head_writes,
  output logic             head_is_store,
  output logic             head_is_branch,
  output logic             head_pred,
  output logic             head_taken,
  output logic [XLEN-1:0]  head_value,
  output logic [XLEN-1:0]  head_pc,
  output logic [XLEN-1:0]  head_imm,
  input  logic             commit
`ifdef ROB_FWD_EN
  ,
  input  logic [TAG_W-1:0] qj_tag,
  input  logic [TAG_W-1:0] qk_tag,
  output logic             qj_ready,
  output logic             qk_ready,
  output logic [XLEN-1:0]  qj_value,
  output logic [XLEN-1:0]  qk_value
`endif
);

  localparam int unsigned CNT_W = TAG_W + 1;

  typedef struct packed {
    logic [4:0]      dest;
    logic            writes;
    logic            is_store;
    logic            is_branch;
    logic            pred;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
  } entry_t;

  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_ready;
  logic [DEPTH-1:0] r_taken;
  logic [XLEN-1:0]  r_value [DEPTH];
  entry_t           r_ent   [DEPTH];

  logic w_full;
  logic w_head_ready;
  logic w_alloc_acc;
  logic w_commit_acc;
  logic w_cdb_acc;
  logic w_store_acc;

  // Full is judged from the registered count only, so a same-cycle commit never frees a slot for alloc.
  assign w_full       = (r_count == CNT_W'(DEPTH));
  assign w_head_ready = r_valid[r_head] && r_ready[r_head];
  assign w_alloc_acc  = alloc_valid && !w_full;
  assign w_commit_acc = commit && w_head_ready;
  assign w_cdb_acc    = cdb_valid && r_valid[cdb_tag] && !r_ent[cdb_tag].is_store;
  assign w_store_acc  = store_done && r_valid[r_head] && r_ent[r_head].is_store;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_ready <= '0;
      r_taken <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_value[i] <= '0;
        r_ent[i]   <= '0;
      end
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_alloc_acc) begin
        r_valid[r_tail] <= 1'b1;
        r_ready[r_tail] <= 1'b0;
        r_taken[r_tail] <= 1'b0;
        r_value[r_tail] <= '0;
        r_ent[r_tail]   <= '{dest: alloc_dest, writes: alloc_writes, is_store: alloc_is_store,
                             is_branch: alloc_is_branch, pred: alloc_pred,
                             pc: alloc_pc, imm: alloc_imm};
        r_tail          <= r_tail + TAG_W'(1);
      end
      if (w_cdb_acc) begin
        r_ready[cdb_tag] <= 1'b1;
        r_value[cdb_tag] <= cdb_value;
        r_taken[cdb_tag] <= cdb_taken;
      end
      if (w_store_acc) begin
        r_ready[r_head] <= 1'b1;
      end
      if (w_commit_acc) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + TAG_W'(1);
      end
      r_count <= r_count + CNT_W'(w_alloc_acc) - CNT_W'(w_commit_acc);
    end
  end

  assign alloc_tag      = r_tail;
  assign full           = w_full;
  assign empty          = (r_count == '0);
  assign count          = r_count;
  assign head_ready     = w_head_ready;
  assign head_tag       = r_head;
  assign head_dest      = r_ent[r_head].dest;
  assign head_writes    = r_ent[r_head].writes;
  assign head_is_store  = r_ent[r_head].is_store;
  assign head_is_branch = r_ent[r_head].is_branch;
  assign head_pred      = r_ent[r_head].pred;
  assign head_taken     = r_taken[r_head];
  assign head_value     = r_value[r_head];
  assign head_pc        = r_ent[r_head].pc;
  assign head_imm       = r_ent[r_head].imm;

`ifdef ROB_FWD_EN
  // Stored result wins; otherwise bypass a CDB broadcast aimed at a valid non-store entry.
  function automatic logic [XLEN:0] lookup(input logic [TAG_W-1:0] t);
    logic [XLEN:0] res;
    res = '0;
    if (r_valid[t] && r_ready[t]) begin
      res = {1'b1, r_value[t]};
    end else if (cdb_valid && (cdb_tag == t) && r_valid[t] && !r_ent[t].is_store) begin
      res = {1'b1, cdb_value};
    end
    return res;
  endfunction

  always_comb begin
    {qj_ready, qj_value} = lookup(qj_tag);
    {qk_ready, qk_value} = lookup(qk_tag);
  end
`endif

endmodule

// File: tb/tb_rob_param.sv
// Self-checking bench for rob_param: directed scenarios plus randomized traffic against a queue model.
module tb_rob_param;

  localparam int DEPTH = 16;
  localparam int XLEN  = 32;
  localparam int TAG_W = 4;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             alloc_valid;
  logic [4:0]       alloc_dest;
  logic             alloc_writes;
  logic             alloc_is_store;
  logic             alloc_is_branch;
  logic             alloc_pred;
  logic [XLEN-1:0]  alloc_pc;
  logic [XLEN-1:0]  alloc_imm;
  logic [TAG_W-1:0] alloc_tag;
  logic             full;
  logic             empty;
  logic [TAG_W:0]   count;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_value;
  logic             cdb_taken;
  logic             store_done;
  logic             head_ready;
  logic [TAG_W-1:0] head_tag;
  logic [4:0]       head_dest;
  logic             head_writes;
  logic             head_is_store;
  logic             head_is_branch;
  logic             head_pred;
  logic             head_taken;
  logic [XLEN-1:0]  head_value;
  logic [XLEN-1:0]  head_pc;
  logic [XLEN-1:0]  head_imm;
  logic             commit;
`ifdef ROB_FWD_EN
  logic [TAG_W-1:0] qj_tag;
  logic [TAG_W-1:0] qk_tag;
  logic             qj_ready;
  logic             qk_ready;
  logic [XLEN-1:0]  qj_value;
  logic [XLEN-1:0]  qk_value;
`endif

  rob_param #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_dest(alloc_dest), .alloc_writes(alloc_writes),
    .alloc_is_store(alloc_is_store), .alloc_is_branch(alloc_is_branch), .alloc_pred(alloc_pred),
    .alloc_pc(alloc_pc), .alloc_imm(alloc_imm), .alloc_tag(alloc_tag),
    .full(full), .empty(empty), .count(count),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_taken(cdb_taken),
    .store_done(store_done), .head_ready(head_ready), .head_tag(head_tag), .head_dest(head_dest),
    .head_writes(head_writes), .head_is_store(head_is_store), .head_is_branch(head_is_branch),
    .head_pred(head_pred), .head_taken(head_taken), .head_value(head_value),
    .head_pc(head_pc), .head_imm(head_imm), .commit(commit)
`ifdef ROB_FWD_EN
    , .qj_tag(qj_tag), .qk_tag(qk_tag), .qj_ready(qj_ready), .qk_ready(qk_ready),
    .qj_value(qj_value), .qk_value(qk_value)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [4:0]  dest;
    logic        wr, st, br, pred;
    logic [31:0] pc, imm, value;
    logic        ready, taken;
  } ment_t;

  ment_t q[$];
  int    m_tail;
  int    total;
  int    bad;

  // Reference: program-order queue of in-flight instructions; tags are handed out modulo DEPTH.
  task automatic model_edge();
    bit    was_full, do_commit;
    ment_t e;
    if (reset || flush) begin
      q.delete();
      m_tail = 0;
      return;
    end
    was_full  = (q.size() == DEPTH);
    do_commit = commit && (q.size() > 0) && q[0].ready;
    if (cdb_valid)
      foreach (q[i])
        if (q[i].tag == int'(cdb_tag) && !q[i].st) begin
          q[i].ready = 1'b1;
          q[i].value = cdb_value;
          q[i].taken = cdb_taken;
        end
    if (store_done && q.size() > 0 && q[0].st) q[0].ready = 1'b1;
    if (do_commit) void'(q.pop_front());
    if (alloc_valid && !was_full) begin
      e.tag = m_tail; e.dest = alloc_dest; e.wr = alloc_writes; e.st = alloc_is_store;
      e.br = alloc_is_branch; e.pred = alloc_pred; e.pc = alloc_pc; e.imm = alloc_imm;
      e.value = '0; e.ready = 1'b0; e.taken = 1'b0;
      q.push_back(e);
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; alloc_valid = 0; alloc_dest = 0; alloc_writes = 0; alloc_is_store = 0;
    alloc_is_branch = 0; alloc_pred = 0; alloc_pc = 0; alloc_imm = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_value = 0; cdb_taken = 0; store_done = 0; commit = 0;
`ifdef ROB_FWD_EN
    qj_tag = 0; qk_tag = 0;
`endif
  endtask

  task automatic set_alloc(input logic [4:0] d, input logic w, input logic s);
    alloc_valid = 1; alloc_dest = d; alloc_writes = w; alloc_is_store = s;
    alloc_is_branch = 1'($urandom); alloc_pred = 1'($urandom);
    alloc_pc = $urandom; alloc_imm = $urandom;
  endtask

  task automatic flush_all();
    idle(); flush = 1; tick(); flush = 0;
  endtask

  task automatic test_reset();
    idle(); reset = 1; tick(); tick(); reset = 0;
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL reset_flags got empty=%b full=%b exp 1 0", empty, full); end
    total++; if (alloc_tag !== 4'd0) begin bad++; $display("FAIL reset_alloc_tag got=%0d exp=0", alloc_tag); end
    total++; if (head_ready !== 1'b0) begin bad++; $display("FAIL reset_head_ready got=%b exp=0", head_ready); end
    total++; if (head_value !== 32'd0 || head_pc !== 32'd0 || head_dest !== 5'd0) begin
      bad++; $display("FAIL reset_head_fields got val=%h pc=%h dest=%0d exp 0", head_value, head_pc, head_dest); end
  endtask

  task automatic test_fill();
    flush_all();
    for (int i = 0; i < DEPTH; i++) begin
      set_alloc(5'(i), 1, 0);
      total++; if (alloc_tag !== 4'(i)) begin bad++; $display("FAIL fill_tag got=%0d exp=%0d", alloc_tag, i); end
      tick();
    end
    total++; if (full !== 1'b1 || count !== 5'd16) begin bad++; $display("FAIL fill_full got full=%b count=%0d exp 1 16", full, count); end
    tick();
    alloc_valid = 0;
    total++; if (count !== 5'd16 || alloc_tag !== 4'd0) begin bad++; $display("FAIL fill_overflow got count=%0d tag=%0d exp 16 0", count, alloc_tag); end
    total++; if (head_dest !== 5'd0 || head_tag !== 4'd0) begin bad++; $display("FAIL fill_head got dest=%0d tag=%0d exp 0 0", head_dest, head_tag); end
  endtask

  task automatic test_cdb_commit();
    flush_all();
    set_alloc(5'd5, 1, 0); tick(); alloc_valid = 0;
    cdb_valid = 1; cdb_tag = 0; cdb_value = 32'hDEADBEEF; cdb_taken = 0;
    total++; if (head_ready !== 1'b0) begin bad++; $display("FAIL cdb_early_ready got=%b exp=0", head_ready); end
    tick(); cdb_valid = 0;
    total++; if (head_ready !== 1'b1 || head_value !== 32'hDEADBEEF || head_dest !== 5'd5) begin
      bad++; $display("FAIL cdb_head got rdy=%b val=%h dest=%0d exp 1 deadbeef 5", head_ready, head_value, head_dest); end
    commit = 1; tick(); commit = 0;
    total++; if (empty !== 1'b1 || count !== 5'd0) begin bad++; $display("FAIL cdb_commit_empty got empty=%b count=%0d exp 1 0", empty, count); end
  endtask

  task automatic test_in_order();
    flush_all();
    set_alloc(5'd1, 1, 0); tick(); set_alloc(5'd2, 1, 0); tick(); alloc_valid = 0;
    cdb_valid = 1; cdb_tag = 1; cdb_value = 32'h11; tick();
    total++; if (head_ready !== 1'b0) begin bad++; $display("FAIL inorder_wait got=%b exp=0", head_ready); end
    cdb_tag = 0; cdb_value = 32'h22; tick(); cdb_valid = 0;
    total++; if (head_ready !== 1'b1 || head_tag !== 4'd0 || head_value !== 32'h22) begin
      bad++; $display("FAIL inorder_first got rdy=%b tag=%0d val=%h exp 1 0 22", head_ready, head_tag, head_value); end
    commit = 1; tick();
    total++; if (head_ready !== 1'b1 || head_tag !== 4'd1 || head_value !== 32'h11) begin
      bad++; $display("FAIL inorder_second got rdy=%b tag=%0d val=%h exp 1 1 11", head_ready, head_tag, head_value); end
    tick(); commit = 0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL inorder_empty got=%b exp=1", empty); end
  endtask

  task automatic test_store();
    flush_all();
    set_alloc(5'd0, 0, 1); tick(); alloc_valid = 0;
    cdb_valid = 1; cdb_tag = 0; cdb_value = 32'h55; tick(); cdb_valid = 0;
    total++; if (head_ready !== 1'b0 || head_is_store !== 1'b1) begin
      bad++; $display("FAIL store_cdb_drop got rdy=%b st=%b exp 0 1", head_ready, head_is_store); end
    store_done = 1; tick(); store_done = 0;
    total++; if (head_ready !== 1'b1) begin bad++; $display("FAIL store_done_ready got=%b exp=1", head_ready); end
    commit = 1; tick(); commit = 0;
    total++; if (empty !== 1'b1 || count !== 5'd0) begin bad++; $display("FAIL store_commit got empty=%b count=%0d exp 1 0", empty, count); end
  endtask

  task automatic test_flush();
    flush_all();
    for (int i = 0; i < 10; i++) begin set_alloc(5'(i), 1, 0); tick(); end
    total++; if (count !== 5'd10) begin bad++; $display("FAIL flush_pre_count got=%0d exp=10", count); end
    set_alloc(5'd9, 1, 0); flush = 1; cdb_valid = 1; cdb_tag = 2; commit = 1;
    tick(); idle();
    total++; if (count !== 5'd0 || empty !== 1'b1 || alloc_tag !== 4'd0 || head_ready !== 1'b0) begin
      bad++; $display("FAIL flush_state got count=%0d empty=%b tag=%0d rdy=%b exp 0 1 0 0", count, empty, alloc_tag, head_ready); end
  endtask

  task automatic test_wrap();
    flush_all();
    set_alloc(5'd3, 1, 0); tick(); alloc_valid = 0;
    for (int k = 0; k < 20; k++) begin
      cdb_valid = 1; cdb_tag = 4'(k % DEPTH); cdb_value = 32'(k); tick(); cdb_valid = 0;
      total++; if (alloc_tag !== 4'((k + 1) % DEPTH)) begin bad++; $display("FAIL wrap_tag k=%0d got=%0d exp=%0d", k, alloc_tag, (k + 1) % DEPTH); end
      set_alloc(5'd3, 1, 0); commit = 1; tick(); alloc_valid = 0; commit = 0;
      total++; if (count !== 5'd1 || head_tag !== 4'((k + 1) % DEPTH)) begin
        bad++; $display("FAIL wrap_step k=%0d got count=%0d head=%0d exp 1 %0d", k, count, head_tag, (k + 1) % DEPTH); end
    end
  endtask

`ifdef ROB_FWD_EN
  task automatic model_lookup(input int t, output logic rdy, output logic [31:0] val);
    rdy = 0; val = 0;
    foreach (q[i])
      if (q[i].tag == t) begin
        if (q[i].ready) begin rdy = 1; val = q[i].value; end
        else if (cdb_valid && int'(cdb_tag) == t && !q[i].st) begin rdy = 1; val = cdb_value; end
      end
  endtask

  task automatic test_fwd();
    flush_all();
    for (int i = 0; i < 4; i++) begin set_alloc(5'(i), 1, 0); tick(); end
    alloc_valid = 0;
    qj_tag = 3; qk_tag = 2; cdb_valid = 1; cdb_tag = 3; cdb_value = 32'd7; #1;
    total++; if (qj_ready !== 1'b1 || qj_value !== 32'd7) begin bad++; $display("FAIL fwd_bypass got rdy=%b val=%0d exp 1 7", qj_ready, qj_value); end
    total++; if (qk_ready !== 1'b0 || qk_value !== 32'd0) begin bad++; $display("FAIL fwd_notready got rdy=%b val=%0d exp 0 0", qk_ready, qk_value); end
    tick(); cdb_valid = 0; #1;
    total++; if (qj_ready !== 1'b1 || qj_value !== 32'd7) begin bad++; $display("FAIL fwd_stored got rdy=%b val=%0d exp 1 7", qj_ready, qj_value); end
  endtask
`endif

  task automatic test_random();
    logic        exp_rdy;
    logic [31:0] exp_val;
    flush_all();
    for (int c = 0; c < 400; c++) begin
      idle();
      flush       = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 1) == 1) set_alloc(5'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
      cdb_valid   = ($urandom_range(0, 9) < 6);
      cdb_tag     = 4'($urandom);
      cdb_value   = $urandom;
      cdb_taken   = 1'($urandom);
      store_done  = ($urandom_range(0, 2) == 0);
      commit      = ($urandom_range(0, 9) < 6);
`ifdef ROB_FWD_EN
      qj_tag = 4'($urandom); qk_tag = 4'($urandom); #1;
      model_lookup(int'(qj_tag), exp_rdy, exp_val);
      total++; if (qj_ready !== exp_rdy || qj_value !== exp_val) begin
        bad++; $display("FAIL rnd_qj c=%0d got rdy=%b val=%h exp %b %h", c, qj_ready, qj_value, exp_rdy, exp_val); end
      model_lookup(int'(qk_tag), exp_rdy, exp_val);
      total++; if (qk_ready !== exp_rdy || qk_value !== exp_val) begin
        bad++; $display("FAIL rnd_qk c=%0d got rdy=%b val=%h exp %b %h", c, qk_ready, qk_value, exp_rdy, exp_val); end
`endif
      tick();
      total++; if (int'(count) != q.size() || empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin
        bad++; $display("FAIL rnd_count c=%0d got count=%0d empty=%b full=%b exp %0d", c, count, empty, full, q.size()); end
      total++; if (int'(alloc_tag) != m_tail) begin bad++; $display("FAIL rnd_alloc_tag c=%0d got=%0d exp=%0d", c, alloc_tag, m_tail); end
      exp_rdy = (q.size() > 0) && q[0].ready;
      total++; if (head_ready !== exp_rdy) begin bad++; $display("FAIL rnd_head_ready c=%0d got=%b exp=%b", c, head_ready, exp_rdy); end
      if (q.size() > 0) begin
        total++; if (int'(head_tag) != q[0].tag || head_dest !== q[0].dest || head_writes !== q[0].wr ||
                     head_is_store !== q[0].st || head_is_branch !== q[0].br || head_pred !== q[0].pred ||
                     head_pc !== q[0].pc || head_imm !== q[0].imm) begin
          bad++; $display("FAIL rnd_head_fields c=%0d got tag=%0d dest=%0d pc=%h exp tag=%0d dest=%0d pc=%h",
                          c, head_tag, head_dest, head_pc, q[0].tag, q[0].dest, q[0].pc); end
        if (q[0].ready) begin
          total++; if (head_value !== q[0].value || head_taken !== q[0].taken) begin
            bad++; $display("FAIL rnd_head_value c=%0d got val=%h tk=%b exp %h %b", c, head_value, head_taken, q[0].value, q[0].taken); end
        end
      end
    end
    idle();
  endtask

  initial begin
    total = 0; bad = 0; m_tail = 0; reset = 1;
    idle();
    test_reset();
    test_fill();
    test_cdb_commit();
    test_in_order();
    test_store();
    test_flush();
    test_wrap();
`ifdef ROB_FWD_EN
    test_fwd();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
